// File: rtl/deskew_buffer_if.sv
// Bus between a 4x4 array's skewed column outputs and the deskew buffer's realigned tile.
// The err line exists only when DESKEW_BUFFER_ERR_EN is defined.
interface deskew_buffer_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [DATA_W-1:0] col0_val;
    logic [DATA_W-1:0] col1_val;
    logic [DATA_W-1:0] col2_val;
    logic [DATA_W-1:0] col3_val;
    logic [DATA_W-1:0] result [15:0];
    logic              out_valid;
    logic              out_ready;
    logic              busy;
`ifdef DESKEW_BUFFER_ERR_EN
    logic              err;

    modport master (
        output start, col0_val, col1_val, col2_val, col3_val, out_ready,
        input  result, out_valid, busy, err
    );
    modport slave (
        input  start, col0_val, col1_val, col2_val, col3_val, out_ready,
        output result, out_valid, busy, err
    );
`else
    modport master (
        output start, col0_val, col1_val, col2_val, col3_val, out_ready,
        input  result, out_valid, busy
    );
    modport slave (
        input  start, col0_val, col1_val, col2_val, col3_val, out_ready,
        output result, out_valid, busy
    );
`endif
endinterface

// File: rtl/deskew_buffer.sv
// Realigns skewed 4x4 array columns into a tile; sticky err output under DESKEW_BUFFER_ERR_EN.
// Latency 7 cycles start->out_valid; tile held until out_ready, new start taken in IDLE or with out_ready in FULL.
module deskew_buffer #(
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    deskew_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t            state_q;
    logic [2:0]        k_q;
    logic [2:0]        k_d;
    logic              out_valid_q;
    logic              busy_q;
    logic              start_acc;
    logic              cap;
    logic [DATA_W-1:0] col [4];

    assign col[0] = bus.col0_val;
    assign col[1] = bus.col1_val;
    assign col[2] = bus.col2_val;
    assign col[3] = bus.col3_val;

    assign start_acc = bus.start &&
                       ((state_q == IDLE) || ((state_q == FULL) && bus.out_ready));
    // k_q rests at 0 outside COLLECT, so the start cycle captures the k=0 diagonal.
    assign cap       = start_acc || (state_q == COLLECT);
    assign k_d       = k_q + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        state_q <= COLLECT;
                        k_q     <= 3'd1;
                        busy_q  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (k_q == 3'd6) begin
                        state_q     <= FULL;
                        k_q         <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        k_q <= k_d;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (start_acc) begin
                            state_q <= COLLECT;
                            k_q     <= 3'd1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Element (r,c) arrives on column c when k == r+c.
    for (genvar i = 0; i < 16; i++) begin : g_elem
        localparam int R = i / 4;
        localparam int C = i % 4;
        logic [DATA_W-1:0] el_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                el_q <= '0;
            end else if (cap && (k_q == 3'(R + C))) begin
                el_q <= col[C];
            end
        end

        assign bus.result[i] = el_q;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

`ifdef DESKEW_BUFFER_ERR_EN
    logic start_ign;
    logic err_q;

    assign start_ign = bus.start &&
                       ((state_q == COLLECT) || ((state_q == FULL) && !bus.out_ready));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (start_ign) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_deskew_buffer.sv
// Directed bench for deskew_buffer: timing, hold, back-to-back, ignored start, reset abort, idle out_ready.
module tb_deskew_buffer;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
`ifdef DESKEW_BUFFER_ERR_EN
    logic err_exp = 1'b0;
`endif

    deskew_buffer_if #(.DATA_W(DATA_W)) bus ();

    deskew_buffer #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] tile_val(input bit second, input int idx);
        int r;
        int c;
        r = idx / 4;
        c = idx % 4;
        return second ? DATA_W'(100 + idx) : DATA_W'(16 * r + c);
    endfunction

    task automatic drive_cols(input bit second, input int j);
        logic [DATA_W-1:0] v [4];
        for (int c = 0; c < 4; c++) begin
            int r;
            r = j - c;
            v[c] = (r >= 0 && r <= 3) ? tile_val(second, r * 4 + c) : DATA_W'(32'hBEEF + c);
        end
        bus.col0_val = v[0];
        bus.col1_val = v[1];
        bus.col2_val = v[2];
        bus.col3_val = v[3];
    endtask

    // Called at the negedge of start cycle T; returns at negedge of T+7 (or T+stop_at).
    task automatic collect(input bit second, input int glitch_at, input int stop_at);
        for (int j = 0; j < 7; j++) begin
            if (j > 0) begin
                @(negedge clk);
                total_cnt++;
                if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0)
                    $display("FAIL collect_flags T+%0d: busy=%b out_valid=%b, required busy=1 out_valid=0",
                             j, bus.busy, bus.out_valid);
                else
                    pass_cnt++;
`ifdef DESKEW_BUFFER_ERR_EN
                total_cnt++;
                if (bus.err !== err_exp)
                    $display("FAIL collect_err T+%0d: err=%b, required %b", j, bus.err, err_exp);
                else
                    pass_cnt++;
`endif
                if (j == stop_at) begin
                    bus.start = 1'b0;
                    return;
                end
            end
            bus.start = (j == 0) || (j == glitch_at);
            drive_cols(second, j);
`ifdef DESKEW_BUFFER_ERR_EN
            if (j == glitch_at) err_exp = 1'b1;
`endif
        end
        @(negedge clk);
        bus.start = 1'b0;
        drive_cols(second, 7);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset_flags: out_valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
        else
            pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (bus.result[i] !== '0)
                $display("FAIL reset_result[%0d]: got %0d, required 0", i, bus.result[i]);
            else
                pass_cnt++;
        end
`ifdef DESKEW_BUFFER_ERR_EN
        total_cnt++;
        if (bus.err !== 1'b0) $display("FAIL reset_err: got %b, required 0", bus.err);
        else pass_cnt++;
`endif
        reset = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        bus.out_ready = 1'b0;
        collect(1'b0, -1, 7);
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL basic_t7: out_valid=%b busy=%b, required 1 0", bus.out_valid, bus.busy);
        else
            pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (bus.result[i] !== tile_val(1'b0, i))
                $display("FAIL basic_result[%0d]: got %0d, required %0d", i, bus.result[i], tile_val(1'b0, i));
            else
                pass_cnt++;
        end
    endtask

    task automatic test_hold();
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.out_valid !== 1'b1)
                $display("FAIL hold_valid cyc%0d: got %b, required 1", n, bus.out_valid);
            else
                pass_cnt++;
            for (int i = 0; i < 16; i++) begin
                total_cnt++;
                if (bus.result[i] !== tile_val(1'b0, i))
                    $display("FAIL hold_result[%0d] cyc%0d: got %0d, required %0d",
                             i, n, bus.result[i], tile_val(1'b0, i));
                else
                    pass_cnt++;
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL hold_release: out_valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
        else
            pass_cnt++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        collect(1'b0, -1, 7);
        total_cnt++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL b2b_first_valid: got %b, required 1", bus.out_valid);
        else
            pass_cnt++;
        bus.out_ready = 1'b1;
        collect(1'b1, -1, 7);
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL b2b_second_t7: out_valid=%b busy=%b, required 1 0", bus.out_valid, bus.busy);
        else
            pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (bus.result[i] !== tile_val(1'b1, i))
                $display("FAIL b2b_result[%0d]: got %0d, required %0d", i, bus.result[i], tile_val(1'b1, i));
            else
                pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL b2b_release: out_valid=%b, required 0", bus.out_valid);
        else
            pass_cnt++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        collect(1'b0, 3, 7);
        total_cnt++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL ign_valid_t7: got %b, required 1", bus.out_valid);
        else
            pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (bus.result[i] !== tile_val(1'b0, i))
                $display("FAIL ign_result[%0d]: got %0d, required %0d", i, bus.result[i], tile_val(1'b0, i));
            else
                pass_cnt++;
        end
        // start while FULL without out_ready must not disturb the held tile.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL ign_full_start: out_valid=%b busy=%b, required 1 0", bus.out_valid, bus.busy);
        else
            pass_cnt++;
`ifdef DESKEW_BUFFER_ERR_EN
        total_cnt++;
        if (bus.err !== 1'b1) $display("FAIL ign_err_sticky: got %b, required 1", bus.err);
        else pass_cnt++;
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL ign_release: out_valid=%b, required 0", bus.out_valid);
        else
            pass_cnt++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        collect(1'b1, -1, 4);
        reset = 1'b0;
`ifdef DESKEW_BUFFER_ERR_EN
        err_exp = 1'b0;
`endif
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL rstmid_flags: out_valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
        else
            pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (bus.result[i] !== '0)
                $display("FAIL rstmid_result[%0d]: got %0d, required 0", i, bus.result[i]);
            else
                pass_cnt++;
        end
`ifdef DESKEW_BUFFER_ERR_EN
        total_cnt++;
        if (bus.err !== 1'b0) $display("FAIL rstmid_err: got %b, required 0", bus.err);
        else pass_cnt++;
`endif
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL rstmid_after cyc%0d: out_valid=%b busy=%b, required 0 0",
                         n, bus.out_valid, bus.busy);
            else
                pass_cnt++;
        end
        collect(1'b0, -1, 7);
        total_cnt++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL rstmid_fresh_valid: got %b, required 1", bus.out_valid);
        else
            pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (bus.result[i] !== tile_val(1'b0, i))
                $display("FAIL rstmid_fresh[%0d]: got %0d, required %0d", i, bus.result[i], tile_val(1'b0, i));
            else
                pass_cnt++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_ready_in_idle();
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL idle_ready cyc%0d: out_valid=%b busy=%b, required 0 0",
                         n, bus.out_valid, bus.busy);
            else
                pass_cnt++;
        end
        collect(1'b0, -1, 7);
        total_cnt++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL idle_ready_t7: out_valid=%b, required 1", bus.out_valid);
        else
            pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (bus.result[i] !== tile_val(1'b0, i))
                $display("FAIL idle_ready_result[%0d]: got %0d, required %0d", i, bus.result[i], tile_val(1'b0, i));
            else
                pass_cnt++;
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL idle_ready_single cyc%0d: out_valid=%b, required 0", n, bus.out_valid);
            else
                pass_cnt++;
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        drive_cols(1'b0, 7);
        reset = 1'b1;
        #2;
        reset = 1'b0;

        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_ready_in_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
